// File: rtl/rfsoc_gpio_cfg_deserializer_pkg.sv
// GPIO bit map, default widths and shared types for the RFSoC GPIO config deserializer.
package rfsoc_config;

  localparam int unsigned GPIO_SDATA        = 0;
  localparam int unsigned GPIO_MASK_CLK     = 1;
  localparam int unsigned GPIO_SEL_CLK      = 2;
  localparam int unsigned GPIO_CYC_CLK      = 3;
  localparam int unsigned GPIO_MUX_SET_CLK  = 4;
  localparam int unsigned GPIO_PL_RST       = 5;
  localparam int unsigned GPIO_TRIGGER      = 6;
  localparam int unsigned GPIO_AVG_CLK      = 7;
  localparam int unsigned GPIO_ACYC_CLK     = 8;
  localparam int unsigned GPIO_USED         = 9;

  localparam int unsigned N_CH_DEF        = 16;
  localparam int unsigned MASK_W_DEF      = 32;
  localparam int unsigned CYC_W_DEF       = 256;
  localparam int unsigned AVG_W_DEF       = 32;
  localparam int unsigned ACYC_W_DEF      = 32;
  localparam int unsigned GPIO_W_DEF      = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef logic [MASK_W_DEF-1:0] mask_t;

endpackage

// File: rtl/rfsoc_gpio_cfg_deserializer_edge_sync.sv
// Multi-flop synchroniser for one GPIO line plus a rising-edge detector on the synchronised level.
module gpio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stage;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stage <= '0;
      dly   <= 1'b0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
      dly   <= stage[SYNC_STAGES-1];
    end
  end

  assign sync = stage[SYNC_STAGES-1];
  assign rise = sync & ~dly;

endmodule

// File: rtl/rfsoc_gpio_cfg_deserializer.sv
// Bit-banged GPIO config deserializer: serial shadows, broadcast channel select, atomic commit on trigger.
// Optional readback of shifted-out bits on rb_sdata when CFG_READBACK_EN is defined.
module rfsoc_gpio_cfg_deserializer
  import rfsoc_config::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int MASK_W      = MASK_W_DEF,
  parameter int CYC_W       = CYC_W_DEF,
  parameter int AVG_W       = AVG_W_DEF,
  parameter int ACYC_W      = ACYC_W_DEF,
  parameter int GPIO_W      = GPIO_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [GPIO_W-1:0]        gpio_in,
  output logic [N_CH*MASK_W-1:0]   ch_mask,
  output logic [N_CH-1:0]          ch_mux,
  output logic [CYC_W-1:0]         cycle_count,
  output logic [AVG_W-1:0]         adc_num_avg,
  output logic [ACYC_W-1:0]        adc_num_cyc,
  output logic                     trig_pulse,
  output logic                     soft_rst,
  output logic                     rb_sdata
);

  logic [GPIO_USED-1:0] sync_v;
  logic [GPIO_USED-1:0] rise_v;

  for (genvar i = 0; i < GPIO_USED; i++) begin : g_sync
    gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (gpio_in[i]),
      .sync (sync_v[i]),
      .rise (rise_v[i])
    );
  end

  if (GPIO_W > GPIO_USED) begin : g_spare
    logic unused_gpio;
    assign unused_gpio = ^gpio_in[GPIO_W-1:GPIO_USED];
  end

  // Not every line needs both its level and its edge.
  logic unused_sync;
  assign unused_sync = ^{sync_v, rise_v};

  logic sdata;
  logic clr;
  assign sdata    = sync_v[GPIO_SDATA];
  assign soft_rst = sync_v[GPIO_PL_RST];
  assign clr      = !rstn || sync_v[GPIO_PL_RST];

  logic [N_CH-1:0]   sel_sh;
  logic [N_CH-1:0]   mux_sh;
  logic [MASK_W-1:0] mask_sh [N_CH];
  logic [CYC_W-1:0]  cyc_sh;
  logic [AVG_W-1:0]  avg_sh;
  logic [ACYC_W-1:0] acyc_sh;

  // Commit reads the pre-shift shadows, so a shift landing with the trigger goes to the next commit.
  always_ff @(posedge clk) begin
    if (clr) begin
      sel_sh      <= '0;
      mux_sh      <= '0;
      cyc_sh      <= '0;
      avg_sh      <= '0;
      acyc_sh     <= '0;
      for (int c = 0; c < N_CH; c++) mask_sh[c] <= '0;
      ch_mask     <= '0;
      ch_mux      <= '0;
      cycle_count <= '0;
      adc_num_avg <= '0;
      adc_num_cyc <= '0;
      trig_pulse  <= 1'b0;
    end else begin
      if (rise_v[GPIO_SEL_CLK]) sel_sh <= {sel_sh[N_CH-2:0], sdata};
      for (int c = 0; c < N_CH; c++) begin
        if (sel_sh[c]) begin
          if (rise_v[GPIO_MASK_CLK])    mask_sh[c] <= {mask_sh[c][MASK_W-2:0], sdata};
          if (rise_v[GPIO_MUX_SET_CLK]) mux_sh[c]  <= sdata;
        end
      end
      if (rise_v[GPIO_CYC_CLK])  cyc_sh  <= {cyc_sh[CYC_W-2:0], sdata};
      if (rise_v[GPIO_AVG_CLK])  avg_sh  <= {avg_sh[AVG_W-2:0], sdata};
      if (rise_v[GPIO_ACYC_CLK]) acyc_sh <= {acyc_sh[ACYC_W-2:0], sdata};

      trig_pulse <= rise_v[GPIO_TRIGGER];
      if (rise_v[GPIO_TRIGGER]) begin
        for (int c = 0; c < N_CH; c++) ch_mask[c*MASK_W +: MASK_W] <= mask_sh[c];
        ch_mux      <= mux_sh;
        cycle_count <= cyc_sh;
        adc_num_avg <= avg_sh;
        adc_num_cyc <= acyc_sh;
      end
    end
  end

`ifdef CFG_READBACK_EN
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [IDX_W-1:0] low_idx;
  logic             low_any;

  always_comb begin
    low_idx = '0;
    low_any = 1'b0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (sel_sh[c]) begin
        low_idx = IDX_W'(c);
        low_any = 1'b1;
      end
    end
  end

  // Simultaneous shifts are rare; a fixed priority picks which bit is reported.
  always_ff @(posedge clk) begin
    if (clr) begin
      rb_sdata <= 1'b0;
    end else if (rise_v[GPIO_MASK_CLK] && low_any) begin
      rb_sdata <= mask_sh[low_idx][MASK_W-1];
    end else if (rise_v[GPIO_MUX_SET_CLK] && low_any) begin
      rb_sdata <= mux_sh[low_idx];
    end else if (rise_v[GPIO_SEL_CLK]) begin
      rb_sdata <= sel_sh[N_CH-1];
    end else if (rise_v[GPIO_CYC_CLK]) begin
      rb_sdata <= cyc_sh[CYC_W-1];
    end else if (rise_v[GPIO_AVG_CLK]) begin
      rb_sdata <= avg_sh[AVG_W-1];
    end else if (rise_v[GPIO_ACYC_CLK]) begin
      rb_sdata <= acyc_sh[ACYC_W-1];
    end
  end
`else
  assign rb_sdata = 1'b0;
`endif

endmodule

// File: tb/tb_rfsoc_gpio_cfg_deserializer.sv
// Scoreboard bench: each trigger pushes the hand-computed active values; a monitor checks them on trig_pulse.
module tb_rfsoc_gpio_cfg_deserializer;
  import rfsoc_config::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [15:0]  gpio = '0;
  logic [511:0] ch_mask;
  logic [15:0]  ch_mux;
  logic [255:0] cycle_count;
  logic [31:0]  adc_num_avg;
  logic [31:0]  adc_num_cyc;
  logic         trig_pulse;
  logic         soft_rst;
  logic         rb_sdata;

  rfsoc_gpio_cfg_deserializer dut (
    .clk         (clk),
    .rstn        (rstn),
    .gpio_in     (gpio),
    .ch_mask     (ch_mask),
    .ch_mux      (ch_mux),
    .cycle_count (cycle_count),
    .adc_num_avg (adc_num_avg),
    .adc_num_cyc (adc_num_cyc),
    .trig_pulse  (trig_pulse),
    .soft_rst    (soft_rst),
    .rb_sdata    (rb_sdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] mask;
    logic [15:0]  mux;
    logic [255:0] cyc;
    logic [31:0]  avg;
    logic [31:0]  acyc;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_trig = 0;
  int    n_pulse = 0;

  mask_t        e_mask [16];
  logic [15:0]  e_mux;
  logic [255:0] e_cyc;
  logic [31:0]  e_avg;
  logic [31:0]  e_acyc;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && trig_pulse) begin
      n_pulse++;
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_trig: got pulse %0d, expected none", n_pulse);
      end else begin
        mon_e = q.pop_front();
        check("ch_mask",     ch_mask,             mon_e.mask);
        check("ch_mux",      512'(ch_mux),        512'(mon_e.mux));
        check("cycle_count", 512'(cycle_count),   512'(mon_e.cyc));
        check("adc_num_avg", 512'(adc_num_avg),   512'(mon_e.avg));
        check("adc_num_cyc", 512'(adc_num_cyc),   512'(mon_e.acyc));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input int line, input logic b);
    gpio[GPIO_SDATA] = b;
    cyc(4);
    gpio[line] = 1'b1;
    cyc(4);
    gpio[line] = 1'b0;
    cyc(4);
  endtask

  task automatic shift_word(input int line, input logic [259:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(line, v[i]);
  endtask

  task automatic push_exp();
    exp_t s;
    for (int c = 0; c < 16; c++) s.mask[c*32 +: 32] = e_mask[c];
    s.mux  = e_mux;
    s.cyc  = e_cyc;
    s.avg  = e_avg;
    s.acyc = e_acyc;
    q.push_back(s);
    n_trig++;
  endtask

  task automatic trigger(input int hold);
    push_exp();
    gpio[GPIO_TRIGGER] = 1'b1;
    cyc(hold);
    gpio[GPIO_TRIGGER] = 1'b0;
    cyc(6);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mask"}, ch_mask, '0);
    check({tag, "_mux"},  512'(ch_mux), '0);
    check({tag, "_cyc"},  512'(cycle_count), '0);
    check({tag, "_avg"},  512'(adc_num_avg), '0);
    check({tag, "_acyc"}, 512'(adc_num_cyc), '0);
  endtask

  logic [255:0] pat;
  logic [31:0]  dw;

  initial begin
    for (int c = 0; c < 16; c++) e_mask[c] = '0;
    e_mux = '0; e_cyc = '0; e_avg = '0; e_acyc = '0;
    pat = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
           64'hDEADBEEFCAFEF00D, 64'h55AA33CC0FF01234};

    // Reset with random GPIO activity
    rstn = 1'b0;
    gpio = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_zero("rst");
      check("rst_trig", 512'(trig_pulse), '0);
      check("rst_soft", 512'(soft_rst), '0);
      gpio = 16'($urandom);
    end
    gpio = '0;
    cyc(2);
    rstn = 1'b1;
    cyc(6);

    // Single-channel mask write
    shift_word(GPIO_SEL_CLK, 260'(16'h0004), 16);
    shift_word(GPIO_MASK_CLK, 260'(32'hDEADBEEF), 32);
    e_mask[2] = 32'hDEADBEEF;
    trigger(4);

`ifdef CFG_READBACK_EN
    dw = 32'hDEADBEEF;
    for (int i = 31; i >= 0; i--) begin
      shift_bit(GPIO_MASK_CLK, dw[i]);
      check($sformatf("rb_bit%0d", i), 512'(rb_sdata), 512'(dw[i]));
    end
`endif

    // Broadcast mux, then masked-off mask write
    shift_word(GPIO_SEL_CLK, 260'(16'h8001), 16);
    shift_bit(GPIO_MUX_SET_CLK, 1'b1);
    e_mux = 16'h8001;
    trigger(4);
    shift_word(GPIO_SEL_CLK, 260'(16'h0000), 16);
    shift_word(GPIO_MASK_CLK, 260'(32'h12345678), 32);
    trigger(4);

    // Over-length cycle_count shift
    shift_word(GPIO_CYC_CLK, {4'hF, pat}, 260);
    check("cyc_pretrig", 512'(cycle_count), '0);
    e_cyc = pat;
    trigger(4);

    // Shift and trigger in the same cycle
    shift_word(GPIO_ACYC_CLK, 260'(32'd5), 32);
    gpio[GPIO_SDATA] = 1'b1;
    cyc(4);
    e_acyc = 32'd5;
    push_exp();
    gpio[GPIO_ACYC_CLK] = 1'b1;
    gpio[GPIO_TRIGGER]  = 1'b1;
    cyc(4);
    gpio[GPIO_ACYC_CLK] = 1'b0;
    gpio[GPIO_TRIGGER]  = 1'b0;
    cyc(6);
    e_acyc = 32'h0000000B;
    trigger(4);

    // Long trigger hold gives one pulse
    trigger(20);

    // pl_rst mid-shift, then a clean write
    shift_word(GPIO_AVG_CLK, 260'(16'hFFFF), 16);
    gpio[GPIO_PL_RST] = 1'b1;
    cyc(4);
    check("soft_rst_hi", 512'(soft_rst), 512'(1));
    gpio[GPIO_PL_RST] = 1'b0;
    cyc(6);
    check_zero("plrst");
    for (int c = 0; c < 16; c++) e_mask[c] = '0;
    e_mux = '0; e_cyc = '0; e_acyc = '0;
    shift_word(GPIO_AVG_CLK, 260'(32'd10), 32);
    e_avg = 32'd10;
    trigger(4);

    cyc(10);
    check("queue_drained", 512'(q.size()), '0);
    check("pulse_count", 512'(n_pulse), 512'(n_trig));
`ifndef CFG_READBACK_EN
    check("rb_tied", 512'(rb_sdata), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
